pic_in_service_control: RTL
===========================

Name: pic_in_service_control

Overview:
- Downstream consumer of the priority resolver's one-hot `interrupt` vector in the 8259-compatible PIC.
- Raises INT and runs the two-pulse 8086-mode INTA sequence.
- Owns the in-service register (ISR) and drives it back to the resolver.
- Executes EOI, automatic-EOI and rotation commands; owns `priority_rotate`.

Parameters:
- NUM_IRQ, 8, number of request levels; fixed at 8, widths below assume it.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- interrupt  in  8  one-hot winner from priority resolver; 0 = none pending
- inta_n  in  1  interrupt acknowledge, active low, already synchronised to clk
- vector_base  in  5  ICW2 T7..T3
- auto_eoi_config  in  1  ICW4 AEOI
- auto_rotate_config  in  1  rotate-on-AEOI mode
- eoi_cmd  in  1  one-cycle OCW2 strobe
- eoi_specific  in  1  with eoi_cmd: 1 = specific, 0 = non-specific
- eoi_rotate  in  1  with eoi_cmd: rotate after clear
- set_priority_cmd  in  1  one-cycle strobe: set lowest priority to cmd_level, no ISR change
- cmd_level  in  3  level for specific EOI / set priority
- int_out  out  1  INT pin to CPU
- in_service_register  out  8  ISR, to resolver
- priority_rotate  out  3  rotation amount, to resolver
- clear_irr  out  8  one-cycle pulse, IRR bit to clear on acknowledge
- data_out  out  8  vector byte
- data_out_en  out  1  drive data bus

Behaviour:
- Reset (rst_n=0 at a clk edge) clears all outputs to 0; state to IDLE; inta_q to 1. Takes priority over every other event, including mid-sequence; any partially acknowledged interrupt is abandoned.
- Edge detect: inta_q <= inta_n.
  - fall = inta_q & ~inta_n
  - rise = ~inta_q & inta_n
- FSM states: IDLE, ACK1, WAIT2, ACK2.
- IDLE:
  - int_out <= |interrupt, a one-cycle registered latency.
  - On fall: go to ACK1.
    - int_out <= 0.
    - lvl <= encode(interrupt).
    - If interrupt != 0: ISR[lvl] <= 1 and clear_irr <= interrupt for one cycle.
    - If interrupt == 0 (spurious): lvl <= 7, no ISR set, no clear_irr.
  - data_out_en stays 0 during the first pulse.
- ACK1: on rise go to WAIT2.
- WAIT2: on fall go to ACK2.
  - data_out <= {vector_base, lvl}; data_out_en <= 1 the next cycle.
- ACK2: on rise go to IDLE; data_out_en <= 0.
  - If auto_eoi_config and not spurious: ISR[lvl] <= 0.
  - If also auto_rotate_config: priority_rotate <= lvl+1.
- INT does not reassert before the FSM returns to IDLE.
- Priority order: level p = priority_rotate has highest priority, then p+1, … wrapping mod 8.
- Non-specific EOI: clears the first set ISR bit scanning p, p+1, …, p+7 mod 8. ISR == 0 makes it a no-op, and no rotation occurs.
- Specific EOI: clears ISR[cmd_level], even if already 0.
- eoi_rotate: after the clear, priority_rotate <= cleared_level+1 mod 8. The cleared level becomes lowest priority.
  - For non-specific EOI with ISR == 0 there is no cleared level, so no rotation (see above).
- set_priority_cmd: priority_rotate <= cmd_level+1 mod 8.
- Simultaneous set_priority_cmd and eoi_cmd: eoi_cmd wins the rotate update.
- Simultaneous EOI and ACK1 ISR set in one cycle:
  - Both apply; the EOI scan uses the pre-set ISR.
  - If both target the same bit, the set wins.
- Simultaneous AEOI clear and an EOI command: both apply (OR of clears).
- Wrap: lvl+1 with lvl = 7 yields 0.
- All arithmetic is 3-bit modulo 8.

Test Plan:
1. Reset mid-sequence: fall with interrupt=8'h04 → ISR=8'h04. Then rst_n=0 during WAIT2 → next cycle ISR=0, int_out=0, data_out_en=0, state IDLE.
2. Basic ack: interrupt=8'h04, vector_base=5'b01000, AEOI=0.
   - int_out=1 one cycle later.
   - First fall → ISR=8'h04, clear_irr=8'h04 for one cycle, int_out=0.
   - Second fall → data_out=8'h42, data_out_en=1.
   - Rise → data_out_en=0, ISR remains 8'h04.
3. Spurious: interrupt drops to 0 before first fall → ISR unchanged, clear_irr=0, second pulse data_out={vector_base,3'd7}.
4. Non-specific EOI with rotation: ISR=8'h81, priority_rotate=7, eoi_cmd, eoi_specific=0, eoi_rotate=1 → ISR=8'h01, priority_rotate=0.
5. AEOI + auto-rotate: interrupt=8'h08, auto_eoi_config=1, auto_rotate_config=1, full sequence → ISR=0 after second rise, priority_rotate=4.
6. Collision: ISR=8'h10, specific EOI cmd_level=4 in the same cycle as first fall with interrupt=8'h02 → ISR=8'h02. Separately, set_priority_cmd with cmd_level=7 → priority_rotate=0.

Source files
------------

// File: rtl/pic_in_service_control.sv
// In-service control for an 8259-compatible PIC: raises INT, runs the 8086-mode
// two-pulse INTA sequence, owns the ISR and the priority rotation, executes EOI commands.
module pic_in_service_control #(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] interrupt,
  input  logic               inta_n,
  input  logic [4:0]         vector_base,
  input  logic               auto_eoi_config,
  input  logic               auto_rotate_config,
  input  logic               eoi_cmd,
  input  logic               eoi_specific,
  input  logic               eoi_rotate,
  input  logic               set_priority_cmd,
  input  logic [2:0]         cmd_level,
  output logic               int_out,
  output logic [NUM_IRQ-1:0] in_service_register,
  output logic [2:0]         priority_rotate,
  output logic [NUM_IRQ-1:0] clear_irr,
  output logic [7:0]         data_out,
  output logic               data_out_en,
  output logic [1:0]         state_dbg
);

  // Handshake: inta_n is a level from the CPU; each falling edge starts an acknowledge
  // pulse and each rising edge ends it. No back-pressure exists on either side.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACK1  = 2'd1,
    S_WAIT2 = 2'd2,
    S_ACK2  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               inta_q;
  logic [2:0]         lvl_q, lvl_d;
  logic               spur_q, spur_d;
  logic               int_out_q, int_out_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [2:0]         rot_q, rot_d;
  logic [NUM_IRQ-1:0] clear_irr_q, clear_irr_d;
  logic [7:0]         data_out_q, data_out_d;
  logic               data_out_en_q, data_out_en_d;

  logic               fall, rise;
  logic [NUM_IRQ-1:0] set_mask, aeoi_clr, eoi_clr;
  logic               aeoi_rot;
  logic               eoi_rot_en;
  logic [2:0]         eoi_lvl;
  logic               ns_found;
  logic [2:0]         ns_level;
  logic [2:0]         scan_idx;

  // Lowest set bit; an empty vector maps to level 7, the spurious level.
  function automatic logic [2:0] encode(input logic [NUM_IRQ-1:0] v);
    encode = 3'd7;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) encode = i[2:0];
    end
  endfunction

  assign fall = inta_q & ~inta_n;
  assign rise = ~inta_q & inta_n;

  // Highest-priority in-service level, scanning from priority_rotate upward.
  always_comb begin
    ns_found = 1'b0;
    ns_level = 3'd0;
    scan_idx = 3'd0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      scan_idx = rot_q + k[2:0];
      if (isr_q[scan_idx]) begin
        ns_found = 1'b1;
        ns_level = scan_idx;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    lvl_d         = lvl_q;
    spur_d        = spur_q;
    int_out_d     = 1'b0;
    clear_irr_d   = '0;
    data_out_d    = data_out_q;
    data_out_en_d = data_out_en_q;
    set_mask      = '0;
    aeoi_clr      = '0;
    aeoi_rot      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        int_out_d = |interrupt;
        if (fall) begin
          state_d   = S_ACK1;
          int_out_d = 1'b0;
          lvl_d     = encode(interrupt);
          spur_d    = ~|interrupt;
          if (|interrupt) begin
            set_mask    = NUM_IRQ'(1) << encode(interrupt);
            clear_irr_d = interrupt;
          end
        end
      end
      S_ACK1: begin
        if (rise) state_d = S_WAIT2;
      end
      S_WAIT2: begin
        if (fall) begin
          state_d       = S_ACK2;
          data_out_d    = {vector_base, lvl_q};
          data_out_en_d = 1'b1;
        end
      end
      S_ACK2: begin
        if (rise) begin
          state_d       = S_IDLE;
          data_out_en_d = 1'b0;
          if (auto_eoi_config && !spur_q) begin
            aeoi_clr = NUM_IRQ'(1) << lvl_q;
            aeoi_rot = auto_rotate_config;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // EOI commands; a non-specific EOI with nothing in service clears and rotates nothing.
  always_comb begin
    eoi_clr    = '0;
    eoi_rot_en = 1'b0;
    eoi_lvl    = 3'd0;
    if (eoi_cmd) begin
      if (eoi_specific) begin
        eoi_lvl    = cmd_level;
        eoi_clr    = NUM_IRQ'(1) << cmd_level;
        eoi_rot_en = eoi_rotate;
      end else if (ns_found) begin
        eoi_lvl    = ns_level;
        eoi_clr    = NUM_IRQ'(1) << ns_level;
        eoi_rot_en = eoi_rotate;
      end
    end
  end

  // Clears use the pre-set ISR; a set on the same bit in the same cycle wins.
  always_comb begin
    isr_d = (isr_q & ~(eoi_clr | aeoi_clr)) | set_mask;
    rot_d = rot_q;
    if (set_priority_cmd && !eoi_cmd) rot_d = cmd_level + 3'd1;
    if (aeoi_rot)                     rot_d = lvl_q + 3'd1;
    if (eoi_rot_en)                   rot_d = eoi_lvl + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      inta_q        <= 1'b1;
      lvl_q         <= 3'd0;
      spur_q        <= 1'b0;
      int_out_q     <= 1'b0;
      isr_q         <= '0;
      rot_q         <= 3'd0;
      clear_irr_q   <= '0;
      data_out_q    <= 8'd0;
      data_out_en_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      inta_q        <= inta_n;
      lvl_q         <= lvl_d;
      spur_q        <= spur_d;
      int_out_q     <= int_out_d;
      isr_q         <= isr_d;
      rot_q         <= rot_d;
      clear_irr_q   <= clear_irr_d;
      data_out_q    <= data_out_d;
      data_out_en_q <= data_out_en_d;
    end
  end

  assign int_out             = int_out_q;
  assign in_service_register = isr_q;
  assign priority_rotate     = rot_q;
  assign clear_irr           = clear_irr_q;
  assign data_out            = data_out_q;
  assign data_out_en         = data_out_en_q;
  assign state_dbg           = state_q;

endmodule
